// File: rtl/multicycle_control_if.sv
// Control/handshake bundle between the multi-cycle sequencer and its datapath/memory.
// master: the sequencer; slave: the datapath side that supplies opcode/flags.
interface multicycle_control_if #(
  parameter int unsigned CNT_WIDTH = 32
);
  logic [6:0]           opcode;
  logic                 zero;
  logic                 mem_ready;
  logic                 pc_write;
  logic                 pc_source;
  logic                 ir_write;
  logic                 iord;
  logic                 mem_read;
  logic                 mem_write;
  logic                 reg_write;
  logic                 memtoreg;
  logic [1:0]           alu_src_a;
  logic [1:0]           alu_src_b;
  logic [1:0]           aluop;
  logic [2:0]           state;
  logic                 illegal;
  logic [CNT_WIDTH-1:0] instret;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, pc_source, ir_write, iord, mem_read, mem_write,
           reg_write, memtoreg, alu_src_a, alu_src_b, aluop, state,
           illegal, instret
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, pc_source, ir_write, iord, mem_read, mem_write,
           reg_write, memtoreg, alu_src_a, alu_src_b, aluop, state,
           illegal, instret
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle RISC-V control sequencer (R-type, addi/slli, lw, sw, beq) with a
// shared ALU and memory port, plus a retired-instruction counter.
module multicycle_control #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input logic                 clk,
  input logic                 rst,
  multicycle_control_if.master bus
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    BRANCH = 3'd5
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] instret_q;
  logic                 retire;

  logic       pc_write, pc_source, ir_write, iord, mem_read, mem_write;
  logic       reg_write, memtoreg, illegal;
  logic [1:0] alu_src_a, alu_src_b, aluop;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= FETCH;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) instret_q <= instret_q + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    state_d   = FETCH;
    retire    = 1'b0;
    pc_write  = 1'b0;
    pc_source = 1'b0;
    ir_write  = 1'b0;
    iord      = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    memtoreg  = 1'b0;
    illegal   = 1'b0;
    alu_src_a = 2'd0;
    alu_src_b = 2'd0;
    aluop     = 2'd0;

    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end else begin
          state_d  = FETCH;
        end
      end
      DECODE: begin
        // ALUOut captures old_pc + imm here so BRANCH can use it as the target.
        alu_src_a = 2'd2;
        alu_src_b = 2'd2;
        case (bus.opcode)
          OP_R, OP_I, OP_LW, OP_SW: state_d = EXEC;
          OP_BEQ:                   state_d = BRANCH;
          default:                  illegal = 1'b1;
        endcase
      end
      EXEC: begin
        alu_src_a = 2'd1;
        case (bus.opcode)
          OP_R: begin
            alu_src_b = 2'd0;
            aluop     = 2'd2;
            state_d   = WB;
          end
          OP_I: begin
            alu_src_b = 2'd2;
            aluop     = 2'd2;
            state_d   = WB;
          end
          OP_LW, OP_SW: begin
            alu_src_b = 2'd2;
            state_d   = MEM;
          end
          default: state_d = FETCH;
        endcase
      end
      MEM: begin
        iord = 1'b1;
        case (bus.opcode)
          OP_LW: begin
            mem_read = 1'b1;
            state_d  = bus.mem_ready ? WB : MEM;
          end
          OP_SW: begin
            mem_write = 1'b1;
            state_d   = bus.mem_ready ? FETCH : MEM;
            retire    = bus.mem_ready;
          end
          default: state_d = FETCH;
        endcase
      end
      WB: begin
        reg_write = 1'b1;
        memtoreg  = (bus.opcode == OP_LW);
        retire    = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd0;
        aluop     = 2'd1;
        pc_source = 1'b1;
        pc_write  = bus.zero;
        retire    = 1'b1;
      end
      default: state_d = FETCH;
    endcase

    // Reset masks every strobe immediately, not just from the next edge.
    if (!rst) begin
      pc_write  = 1'b0;
      pc_source = 1'b0;
      ir_write  = 1'b0;
      iord      = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      memtoreg  = 1'b0;
      illegal   = 1'b0;
      alu_src_a = 2'd0;
      alu_src_b = 2'd0;
      aluop     = 2'd0;
    end
  end

  assign bus.pc_write  = pc_write;
  assign bus.pc_source = pc_source;
  assign bus.ir_write  = ir_write;
  assign bus.iord      = iord;
  assign bus.mem_read  = mem_read;
  assign bus.mem_write = mem_write;
  assign bus.reg_write = reg_write;
  assign bus.memtoreg  = memtoreg;
  assign bus.alu_src_a = alu_src_a;
  assign bus.alu_src_b = alu_src_b;
  assign bus.aluop     = aluop;
  assign bus.illegal   = illegal;
  assign bus.state     = state_q;
  assign bus.instret   = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction phase traces built from the
// instruction class and memory wait counts, checked cycle by cycle.
module tb_multicycle_control;

  localparam int unsigned CW = 4;

  localparam int K_R = 0, K_I = 1, K_L = 2, K_S = 3, K_B = 4, K_X = 5;
  localparam int P_F = 0, P_D = 1, P_E = 2, P_M = 3, P_W = 4, P_B = 5;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  logic [CW-1:0] exp_instret = '0;
  logic [14:0]   act_vec;

  multicycle_control_if #(.CNT_WIDTH(CW)) bus ();

  multicycle_control #(.CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  assign act_vec = {bus.pc_write, bus.pc_source, bus.ir_write, bus.iord,
                    bus.mem_read, bus.mem_write, bus.reg_write, bus.memtoreg,
                    bus.alu_src_a, bus.alu_src_b, bus.aluop, bus.illegal};

  function automatic int classify(input logic [6:0] op);
    case (op)
      7'b0110011: return K_R;
      7'b0010011: return K_I;
      7'b0000011: return K_L;
      7'b0100011: return K_S;
      7'b1100011: return K_B;
      default:    return K_X;
    endcase
  endfunction

  // Expected strobes for one cycle of the given phase, straight from the control table.
  function automatic logic [14:0] exp_vec(input int ph, input int kind,
                                          input logic rdy, input logic z);
    logic pw = 0, ps = 0, irw = 0, io = 0, mr = 0, mw = 0, rw = 0, mtr = 0, ill = 0;
    logic [1:0] sa = 0, sb = 0, op = 0;
    case (ph)
      P_F: begin mr = 1; sb = 1; irw = rdy; pw = rdy; end
      P_D: begin sa = 2; sb = 2; ill = (kind == K_X); end
      P_E: begin
        sa = 1;
        sb = (kind == K_R) ? 2'd0 : 2'd2;
        op = (kind == K_R || kind == K_I) ? 2'd2 : 2'd0;
      end
      P_M: begin io = 1; mr = (kind == K_L); mw = (kind == K_S); end
      P_W: begin rw = 1; mtr = (kind == K_L); end
      P_B: begin sa = 1; sb = 0; op = 1; ps = 1; pw = z; end
      default: ;
    endcase
    return {pw, ps, irw, io, mr, mw, rw, mtr, sa, sb, op, ill};
  endfunction

  task automatic run_instr(input logic [31:0] word, input int wf, input int wm,
                           input logic z, input string name);
    logic [6:0] op;
    int         kind;
    int         ph[$];
    logic       rq[$];
    logic       zz;
    op   = word[6:0];
    kind = classify(op);
    for (int i = 0; i < wf; i++) begin ph.push_back(P_F); rq.push_back(1'b0); end
    ph.push_back(P_F); rq.push_back(1'b1);
    ph.push_back(P_D); rq.push_back(1'($urandom));
    if (kind == K_R || kind == K_I || kind == K_L || kind == K_S) begin
      ph.push_back(P_E); rq.push_back(1'($urandom));
    end
    if (kind == K_L || kind == K_S) begin
      for (int i = 0; i < wm; i++) begin ph.push_back(P_M); rq.push_back(1'b0); end
      ph.push_back(P_M); rq.push_back(1'b1);
    end
    if (kind == K_R || kind == K_I || kind == K_L) begin
      ph.push_back(P_W); rq.push_back(1'($urandom));
    end
    if (kind == K_B) begin
      ph.push_back(P_B); rq.push_back(1'($urandom));
    end

    for (int i = 0; i < ph.size(); i++) begin
      @(negedge clk);
      bus.opcode    = (ph[i] == P_F) ? 7'($urandom) : op;
      bus.mem_ready = rq[i];
      zz            = (ph[i] == P_B) ? z : 1'($urandom);
      bus.zero      = zz;
      #1;
      tests++;
      if (bus.state !== 3'(ph[i])) begin
        fails++;
        $display("FAIL %s cyc%0d state: got %0d expected %0d", name, i, bus.state, ph[i]);
      end
      tests++;
      if (act_vec !== exp_vec(ph[i], kind, rq[i], zz)) begin
        fails++;
        $display("FAIL %s cyc%0d strobes: got %b expected %b", name, i, act_vec,
                 exp_vec(ph[i], kind, rq[i], zz));
      end
    end
    if (kind != K_X) exp_instret = exp_instret + 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (bus.state !== 3'd0) begin
      fails++;
      $display("FAIL %s end state: got %0d expected 0", name, bus.state);
    end
    tests++;
    if (bus.instret !== exp_instret) begin
      fails++;
      $display("FAIL %s instret: got %0d expected %0d", name, bus.instret, exp_instret);
    end
  endtask

  task automatic test_reset();
    rst           = 1'b0;
    bus.mem_ready = 1'b1;
    bus.opcode    = 7'h33;
    bus.zero      = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1;
      tests++;
      if (act_vec !== 15'd0) begin
        fails++;
        $display("FAIL reset strobes: got %b expected 0", act_vec);
      end
    end
    @(posedge clk);
    #1;
    tests++;
    if (bus.state !== 3'd0 || bus.instret !== '0) begin
      fails++;
      $display("FAIL reset state/instret: got %0d/%0d expected 0/0", bus.state, bus.instret);
    end
    exp_instret   = '0;
    rst           = 1'b1;
    bus.mem_ready = 1'b0;
  endtask

  task automatic test_reset_mid_sw();
    logic [6:0] ops[4];
    ops = '{7'h11, 7'h23, 7'h23, 7'h23};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.opcode    = ops[i];
      bus.mem_ready = (i == 0);
      #1;
      tests++;
      if (bus.state !== 3'(i)) begin
        fails++;
        $display("FAIL sw_rst cyc%0d state: got %0d expected %0d", i, bus.state, i);
      end
    end
    tests++;
    if (bus.mem_write !== 1'b1 || bus.iord !== 1'b1) begin
      fails++;
      $display("FAIL sw_rst mem strobes: got mw=%b iord=%b expected 1/1", bus.mem_write, bus.iord);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (act_vec !== 15'd0) begin
      fails++;
      $display("FAIL sw_rst forced zero: got %b expected 0", act_vec);
    end
    @(posedge clk);
    #1;
    tests++;
    if (bus.state !== 3'd0 || bus.instret !== '0) begin
      fails++;
      $display("FAIL sw_rst after edge: got state %0d instret %0d expected 0/0", bus.state, bus.instret);
    end
    exp_instret   = '0;
    rst           = 1'b1;
    bus.mem_ready = 1'b0;
    run_instr(32'h00202223, 0, 0, 1'b0, "sw_resume");
  endtask

  task automatic test_random(input int n);
    logic [6:0] ops[5];
    logic [6:0] op;
    int         k;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};
    for (int i = 0; i < n; i++) begin
      k = $urandom_range(0, 5);
      if (k < 5) op = ops[k];
      else begin
        op = 7'($urandom);
        while (classify(op) != K_X) op = op + 7'd1;
      end
      run_instr({$urandom, 7'b0} | 32'(op), $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom), "random");
    end
  endtask

  initial begin
    rst = 1'b0;
    bus.opcode = '0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;
    test_reset();
    run_instr(32'h00210233, 0, 0, 1'b0, "add");
    run_instr(32'h0000a003, 0, 2, 1'b0, "lw_wait");
    run_instr(32'h00000063, 0, 0, 1'b1, "beq_taken");
    run_instr(32'h00000063, 0, 0, 1'b0, "beq_not_taken");
    run_instr(32'h0000007f, 0, 0, 1'b0, "illegal");
    run_instr(32'h00110113, 3, 0, 1'b0, "fetch_wait");
    test_reset_mid_sw();
    test_random(40);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
